decode_stage: RTL and testbench

//  Registered RV32I decode stage between fetch and execute. Accepts one instruction + PC per

---
 rtl/decode_stage.sv | 273 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I decode stage sitting between fetch and execute. Each
// accepted instruction is decoded (register fields, sign-extended immediate,
// format class, source/destination usage, illegal-encoding flag) and held in
// a single pipeline register until execute consumes it.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer; ready may depend combinationally on the
// consumer's ready, but valid never depends on ready.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   flush             drop the held instruction; blocks input that cycle
//   in_valid/in_ready fetch-side handshake
//   in_instr, in_pc   raw instruction word and its address
//   out_valid/out_ready execute-side handshake
//   out_pc            registered in_pc
//   out_opcode/funct3/funct7/rd/rs1/rs2  raw instruction fields
//   out_imm           sign-extended immediate (0 for R format)
//   out_fmt           0=R 1=I 2=S 3=B 4=U 5=J
//   out_rs1_used/out_rs2_used  true register sources (hazard detection)
//   out_rd_wr         writes a non-zero rd
//   out_illegal       illegal encoding, carried down the pipe for a trap
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter bit RV32E = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_wr,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_wr;
        logic            illegal;
    } payload_t;

    payload_t payload_q, payload_d;
    logic     valid_q, valid_d;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    fmt_e        dec_fmt;
    logic        dec_rs1_used, dec_rs2_used, dec_writes_rd, dec_illegal;
    logic [31:0] imm32;
    logic        s;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign s      = in_instr[31];

    always_comb begin
        dec_fmt       = FMT_I;
        dec_rs1_used  = 1'b0;
        dec_rs2_used  = 1'b0;
        dec_writes_rd = 1'b0;
        dec_illegal   = 1'b0;

        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_fmt       = FMT_U;
                dec_writes_rd = 1'b1;
            end
            OP_JAL: begin
                dec_fmt       = FMT_J;
                dec_writes_rd = 1'b1;
            end
            OP_JALR: begin
                dec_rs1_used  = 1'b1;
                dec_writes_rd = 1'b1;
                dec_illegal   = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                dec_fmt      = FMT_B;
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
                dec_illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                dec_rs1_used  = 1'b1;
                dec_writes_rd = 1'b1;
                dec_illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                (funct3 == 3'b111);
            end
            OP_STORE: begin
                dec_fmt      = FMT_S;
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
                dec_illegal  = (funct3 >= 3'b011);
            end
            OP_IMM: begin
                dec_rs1_used  = 1'b1;
                dec_writes_rd = 1'b1;
                // Shift-immediates reuse funct7 as an encoding field.
                if (funct3 == 3'b001)
                    dec_illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OP_OP: begin
                dec_fmt       = FMT_R;
                dec_rs1_used  = 1'b1;
                dec_rs2_used  = 1'b1;
                dec_writes_rd = 1'b1;
                if (funct7 == 7'b0100000)
                    dec_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                else
                    dec_illegal = (funct7 != 7'b0000000);
            end
            OP_MISC, OP_SYSTEM: begin
                dec_fmt = FMT_I;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (in_instr[1:0] != 2'b11)
            dec_illegal = 1'b1;

        // The 16-register base only rejects indices that are actually used.
        if (RV32E) begin
            if ((dec_rs1_used && rs1[4]) || (dec_rs2_used && rs2[4]) ||
                (dec_writes_rd && rd[4]))
                dec_illegal = 1'b1;
        end

        // Illegal instructions travel as inert I-format so hazard logic ignores them.
        if (dec_illegal) begin
            dec_fmt       = FMT_I;
            dec_rs1_used  = 1'b0;
            dec_rs2_used  = 1'b0;
            dec_writes_rd = 1'b0;
        end
    end

    always_comb begin
        imm32 = 32'd0;
        case (dec_fmt)
            FMT_I:   imm32 = {{20{s}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{s}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{19{s}}, in_instr[31], in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'd0};
            FMT_J:   imm32 = {{11{s}}, in_instr[31], in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline register with backpressure and flush
    // ------------------------------------------------------------------
    logic load;

    assign in_ready = !reset && !flush && (!valid_q || out_ready);
    assign load     = in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d            = 1'b1;
            payload_d.pc       = in_pc;
            payload_d.opcode   = opcode;
            payload_d.funct3   = funct3;
            payload_d.funct7   = funct7;
            payload_d.rd       = rd;
            payload_d.rs1      = rs1;
            payload_d.rs2      = rs2;
            // Sign-extend from bit 31 out to XLEN.
            payload_d.imm      = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
            payload_d.fmt      = dec_fmt;
            payload_d.rs1_used = dec_rs1_used;
            payload_d.rs2_used = dec_rs2_used;
            payload_d.rd_wr    = dec_writes_rd && (rd != 5'd0);
            payload_d.illegal  = dec_illegal;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = payload_q.pc;
    assign out_opcode   = payload_q.opcode;
    assign out_funct3   = payload_q.funct3;
    assign out_funct7   = payload_q.funct7;
    assign out_rd       = payload_q.rd;
    assign out_rs1      = payload_q.rs1;
    assign out_rs2      = payload_q.rs2;
    assign out_imm      = payload_q.imm;
    assign out_fmt      = payload_q.fmt;
    assign out_rs1_used = payload_q.rs1_used;
    assign out_rs2_used = payload_q.rs2_used;
    assign out_rd_wr    = payload_q.rd_wr;
    assign out_illegal  = payload_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_rs1_used, out_rs2_used, out_rd_wr, out_illegal;

  // RV32E instance fed from the same stimulus
  logic        e_in_ready, e_out_valid;
  logic [31:0] e_out_pc, e_out_imm;
  logic [6:0]  e_out_opcode, e_out_funct7;
  logic [2:0]  e_out_funct3, e_out_fmt;
  logic [4:0]  e_out_rd, e_out_rs1, e_out_rs2;
  logic        e_out_rs1_used, e_out_rs2_used, e_out_rd_wr, e_out_illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_rd_wr(out_rd_wr), .out_illegal(out_illegal)
  );

  decode_stage #(.RV32E(1'b1)) dut_e (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
    .out_opcode(e_out_opcode), .out_funct3(e_out_funct3), .out_funct7(e_out_funct7),
    .out_rd(e_out_rd), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_imm(e_out_imm),
    .out_fmt(e_out_fmt), .out_rs1_used(e_out_rs1_used), .out_rs2_used(e_out_rs2_used),
    .out_rd_wr(e_out_rd_wr), .out_illegal(e_out_illegal)
  );

  logic [102:0] snap;
  assign snap = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                 out_imm, out_fmt, out_rs1_used, out_rs2_used, out_rd_wr, out_illegal};

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        rs1u;
    logic        rs2u;
    logic        rdwr;
    logic        ill;
    logic        ill_e;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cur_idx  = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic         stall_prev = 1'b0;
  logic [102:0] snap_prev;
  logic [31:0]  m_idx;
  vec_t         m_v;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_stable", snap, snap_prev);
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 1'b0);

      if (out_valid && (flush || out_ready)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          m_idx = exp_q.pop_front();
          if (!flush) begin
            m_v = vecs[m_idx];
            check("pc",      out_pc, 32'h1000 + m_idx * 4);
            check("opcode",  out_opcode, m_v.instr[6:0]);
            check("funct3",  out_funct3, m_v.instr[14:12]);
            check("funct7",  out_funct7, m_v.instr[31:25]);
            check("rd",      out_rd,  m_v.instr[11:7]);
            check("rs1",     out_rs1, m_v.instr[19:15]);
            check("rs2",     out_rs2, m_v.instr[24:20]);
            check("fmt",     out_fmt, m_v.fmt);
            check("imm",     out_imm, m_v.imm);
            check("rs1_used", out_rs1_used, m_v.rs1u);
            check("rs2_used", out_rs2_used, m_v.rs2u);
            check("rd_wr",   out_rd_wr, m_v.rdwr);
            check("illegal", out_illegal, m_v.ill);
            check("e_illegal", e_out_illegal, m_v.ill_e);
            check("e_rd_wr", e_out_rd_wr, m_v.rdwr & ~m_v.ill_e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(32'(cur_idx));

      stall_prev = out_valid && !out_ready && !flush;
      snap_prev  = snap;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int idx);
    int waited = 0;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_pc    = 32'h1000 + 32'(idx) * 4;
    cur_idx  = idx;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  int c0;

  initial begin
    vecs[0]  = '{32'hFFF10093, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // ADDI x1,x2,-1
    vecs[1]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // BEQ -4
    vecs[2]  = '{32'h0010006F, 3'd5, 32'h00000800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // JAL x0,+2048
    vecs[3]  = '{32'h123452B7, 3'd4, 32'h12345000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // LUI
    vecs[4]  = '{32'h00512423, 3'd2, 32'h00000008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // SW
    vecs[5]  = '{32'h002081B3, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // ADD
    vecs[6]  = '{32'h402081B3, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // SUB
    vecs[7]  = '{32'hFFFFF517, 3'd4, 32'hFFFFF000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // AUIPC
    vecs[8]  = '{32'hFF80A383, 3'd1, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // LW -8
    vecs[9]  = '{32'h000280E7, 3'd1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // JALR
    vecs[10] = '{32'h000290E7, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // JALR f3=1
    vecs[11] = '{32'h40315093, 3'd1, 32'h00000403, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // SRAI
    vecs[12] = '{32'h40311093, 3'd1, 32'h00000403, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // SLLI bad f7
    vecs[13] = '{32'h00000000, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // all zero
    vecs[14] = '{32'h0000207B, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // bad opcode
    vecs[15] = '{32'h40001033, 3'd1, 32'h00000400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // SUB-style f3=1
    vecs[16] = '{32'h00002063, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // BRANCH f3=2
    vecs[17] = '{32'h00000073, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // ECALL
    vecs[18] = '{32'h0FF0000F, 3'd1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // FENCE
    vecs[19] = '{32'h00208833, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // ADD x16

    // Reset held two cycles with a valid input offered
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = vecs[0].instr;
    in_pc     = 32'h1000;
    repeat (2) begin
      @(negedge clk);
      check("reset_in_ready", in_ready, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_outputs", snap, '0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;

    // Single-cycle latency on the first transaction
    send(0);
    check("latency_valid", out_valid, 1'b1);
    check("latency_pc", out_pc, 32'h1000);

    // Remaining table back-to-back: one acceptance per cycle
    c0 = cyc;
    for (int i = 1; i < NV; i++) send(i);
    check("throughput_cycles", cyc - c0, NV - 1);
    drain();

    // Stream of four with execute stalling for two cycles
    @(posedge clk);
    #1;
    fork
      begin
        send(3);
        send(4);
        send(5);
        send(6);
      end
      begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush while stalled with a new instruction offered
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8);
    check("pre_flush_valid", out_valid, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = vecs[9].instr;
    in_pc    = 32'h1000 + 9 * 4;
    cur_idx  = 9;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("flush_not_taken", out_valid, 1'b0);
    check("flush_queue", exp_q.size(), 0);
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
